// File: rtl/core_run_ctrl.sv
// core_run_ctrl: owns the core reset, counts RUN cycles and stops the run on
// halt, PC self-loop or cycle budget, latching the cause and the cycle count.
module core_run_ctrl #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned LOOP_CYCLES  = 4,
  parameter int unsigned AUTO_START   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 halt,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 core_rst_n,
  output logic                 running,
  output logic                 done,
  output logic                 halted,
  output logic                 looped,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned RW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned LW        = (LOOP_CYCLES > 1) ? $clog2(LOOP_CYCLES) : 1;
  localparam int unsigned RST_LAST  = (RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0;
  localparam int unsigned LOOP_LAST = (LOOP_CYCLES > 0) ? LOOP_CYCLES - 1 : 0;
  localparam int unsigned CNT_LAST  = (MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0;
  localparam bit          LOOP_EN   = (LOOP_CYCLES != 0);
  localparam bit          AUTO      = (AUTO_START != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
  logic [LW-1:0]         loop_cnt_q, loop_cnt_d;
  logic [PC_WIDTH-1:0]   prev_pc_q, prev_pc_d;
  logic                  pc_valid_q, pc_valid_d;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  halted_d, looped_d, timeout_d;
  logic                  pc_same;

  // Equal-PC comparison is only meaningful once prev_pc holds a RUN sample
  assign pc_same = pc_valid_q && (pc == prev_pc_q);

  // Next-state and next-value logic for the run sequencer
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    loop_cnt_d = loop_cnt_q;
    prev_pc_d  = prev_pc_q;
    pc_valid_d = pc_valid_q;
    cnt_d      = cycle_count;
    halted_d   = halted;
    looped_d   = looped;
    timeout_d  = timeout;

    case (state_q)
      ST_IDLE: begin
        if (start || AUTO) begin
          state_d    = ST_RESET;
          rst_cnt_d  = '0;
          loop_cnt_d = '0;
          pc_valid_d = 1'b0;
          cnt_d      = '0;
          halted_d   = 1'b0;
          looped_d   = 1'b0;
          timeout_d  = 1'b0;
        end
      end

      ST_RESET: begin
        if (rst_cnt_q == RW'(RST_LAST)) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        cnt_d      = cycle_count + 1'b1;
        prev_pc_d  = pc;
        pc_valid_d = 1'b1;
        if (LOOP_EN && pc_same) begin
          loop_cnt_d = loop_cnt_q + 1'b1;
        end else begin
          loop_cnt_d = '0;
        end

        if (halt) begin
          state_d  = ST_DONE;
          halted_d = 1'b1;
        end else if (LOOP_EN && pc_same && (loop_cnt_q == LW'(LOOP_LAST))) begin
          state_d  = ST_DONE;
          looped_d = 1'b1;
        end else if (cycle_count == CNT_WIDTH'(CNT_LAST)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d    = ST_RESET;
          rst_cnt_d  = '0;
          loop_cnt_d = '0;
          pc_valid_d = 1'b0;
          cnt_d      = '0;
          halted_d   = 1'b0;
          looped_d   = 1'b0;
          timeout_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered Moore outputs; reset clears everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      loop_cnt_q  <= '0;
      prev_pc_q   <= '0;
      pc_valid_q  <= 1'b0;
      cycle_count <= '0;
      halted      <= 1'b0;
      looped      <= 1'b0;
      timeout     <= 1'b0;
      core_rst_n  <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      loop_cnt_q  <= loop_cnt_d;
      prev_pc_q   <= prev_pc_d;
      pc_valid_q  <= pc_valid_d;
      cycle_count <= cnt_d;
      halted      <= halted_d;
      looped      <= looped_d;
      timeout     <= timeout_d;
      core_rst_n  <= (state_d == ST_RUN);
      running     <= (state_d == ST_RUN);
      done        <= (state_d == ST_DONE);
    end
  end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Parametrised run controller for the single-cycle RISC-V core in simulation and FPGA bring-up. It owns the core's reset: it holds the core in reset for a programmed number of cycles, releases it, and counts executed cycles. It stops the run on one of three causes: an explicit halt from the core, a self-loop on the PC (`j .`), or a cycle budget. It latches the stop cause and cycle count so a bench or debug register can read them instead of relying on a fixed wall-clock `$finish`.

## Interface
Parameters:
- PC_WIDTH, 32, width of the observed PC.
- CNT_WIDTH, 32, width of cycle_count; must hold MAX_CYCLES.
- RESET_CYCLES, 2, cycles core_rst_n is held low in RESET; must be ≥1.
- MAX_CYCLES, 1000, run budget in RUN cycles; must be ≥1.
- LOOP_CYCLES, 4, consecutive equal-PC comparisons that end a run; 0 disables loop detection.
- AUTO_START, 1, 1 means IDLE leaves automatically after reset; 0 means it waits for start.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- start  in  1  single-cycle request to (re)start a run; honoured in IDLE and DONE only.
- halt  in  1  core halt indication (ecall/ebreak decoded); sampled in RUN.
- pc  in  PC_WIDTH  core PC; sampled in RUN.
- core_rst_n  out  1  active-low reset to the core; 1 only in RUN.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- halted  out  1  latched stop cause: halt.
- looped  out  1  latched stop cause: PC self-loop.
- timeout  out  1  latched stop cause: budget exhausted.
- cycle_count  out  CNT_WIDTH  RUN cycles completed.

## Operation
- States: IDLE, RESET, RUN, DONE. Registered Moore outputs.
- Reset (rst=1): state forced to IDLE. All outputs are 0, including core_rst_n, so the core is in reset. Internal counters and prev_pc are cleared.
- IDLE → RESET: on an edge with start=1 or AUTO_START=1. Clears halted/looped/timeout and cycle_count.
- RESET: rst_cnt counts edges. After RESET_CYCLES edges → RUN.
- RUN: core_rst_n=1 and running=1.
  - cycle_count increments on every edge in RUN.
  - prev_pc captures pc every edge.
  - The first RUN cycle has no valid prev_pc, so no comparison is made.
  - loop_cnt increments on each edge where pc==prev_pc and clears otherwise.
- RUN exit, evaluated per edge in priority order. Exactly one cause flag is set.
  1. halt=1 → DONE, halted=1.
  2. LOOP_CYCLES≠0, pc==prev_pc and loop_cnt==LOOP_CYCLES-1 → DONE, looped=1.
  3. cycle_count==MAX_CYCLES-1 → DONE, timeout=1.
- The exit edge still increments cycle_count, so the halting cycle is counted.
- DONE:
  - core_rst_n=0 (core frozen); done=1; flags and cycle_count held.
  - start=1 → RESET, clearing flags and cycle_count. AUTO_START has no effect in DONE.
- start in RESET or RUN is ignored.
- cycle_count never wraps; MAX_CYCLES bounds it.

## Timing
- After rst falls with AUTO_START=1:
  - edge 1: IDLE→RESET;
  - edge 1+RESET_CYCLES: RESET→RUN. core_rst_n rises after this edge.
- With AUTO_START=0, IDLE→RESET occurs on the first edge where start=1.
- Stop latency is one edge. The cause is sampled on edge k; done, the flag and core_rst_n=0 are visible after edge k.
- rst asserted mid-operation, in any state: core_rst_n and every output go to 0 immediately, without a clock edge. Restart follows the normal IDLE rules.
- halt or pc changing during RESET or DONE is ignored.

## Test plan
- Reset release, AUTO_START=1, RESET_CYCLES=2: rst high 3 cycles then low → core_rst_n low for exactly 3 more edges, then high with running=1 and cycle_count=0.
- Halt: pc +4 per cycle from 0x0, halt=1 during RUN cycle with cycle_count=9 → next edge done=1, halted=1, looped=0, timeout=0, cycle_count=10, core_rst_n=0.
- Loop, LOOP_CYCLES=4: pc +4 per cycle, then stuck at 0x40 from RUN cycle 5 onward:
  - equal-PC comparisons on cycles 6–9;
  - done after cycle 9's edge with looped=1 and cycle_count=10.
  - Repeat with LOOP_CYCLES=0 → runs to timeout.
- Timeout, MAX_CYCLES=16: pc +4 per cycle, no halt → done after 16 RUN edges, timeout=1, cycle_count=16.
  - Also drive halt=1 on that same final cycle → halted=1, timeout=0.
- Restart and mid-run reset:
  - start pulse in DONE → flags and cycle_count clear, 2 RESET edges, new RUN.
  - start pulse in RUN → no effect.
  - rst raised mid-RUN between clock edges → core_rst_n=0 and all outputs 0 without waiting for an edge.
